// File: rtl/dcache_dm_wb.sv
// dcache_dm_wb: direct-mapped, write-back, write-allocate data cache.
//
// Sits between the pipeline MEM stage and a slow block memory. It answers
// processor requests, and on a miss it writes the dirty victim back if
// needed, then fills the line. A write miss finishes as a hit in the cycle
// after the fill.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   proc_read, proc_write    processor request (both high = write)
//   proc_addr[29:0]          word address {tag, index, offset[1:0]}
//   proc_wdata[31:0]         write data
//   proc_stall               request not yet complete
//   proc_rdata[31:0]         read data of the addressed word (0 if line invalid)
//   mem_read, mem_write      registered block read / write request
//   mem_addr[27:0]           registered block address {tag, index}
//   mem_wdata[127:0]         registered victim block, word0 at [31:0]
//   mem_ready                one-cycle completion pulse from memory
//   mem_rdata[127:0]         fill block, valid with mem_ready
module dcache_dm_wb #(
  parameter int unsigned INDEX_W     = 3,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata
);

  localparam int unsigned NUM_BLOCKS = 2 ** INDEX_W;
  localparam int unsigned TAG_W      = 28 - INDEX_W;
  localparam int unsigned LINE_W     = 32 * BLOCK_WORDS;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StAllocate
  } state_e;

  state_e state_q;

  // Line state. Only valid/dirty are reset; tag/data are qualified by valid.
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

  // Registered memory-side outputs.
  logic         mem_read_q;
  logic         mem_write_q;
  logic [27:0]  mem_addr_q;
  logic [127:0] mem_wdata_q;

  // Address fields.
  logic [1:0]         off;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   ptag;

  assign off  = proc_addr[1:0];
  assign idx  = proc_addr[INDEX_W+1:2];
  assign ptag = proc_addr[29:INDEX_W+2];

  logic              req;
  logic              hit;
  logic              line_valid;
  logic              line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;
  logic [LINE_W-1:0] line_merged;
  logic [31:0]       line_word;
  logic              write_hit;
  logic              fill;

  always_comb begin
    req        = proc_read | proc_write;
    line_valid = valid_q[idx];
    line_dirty = dirty_q[idx];
    line_tag   = tag_q[idx];
    line_data  = data_q[idx];
    hit        = line_valid & (line_tag == ptag);
    line_word  = line_data[{off, 5'b0} +: 32];
    // Line image with the processor word patched in, used on a write hit.
    line_merged                   = line_data;
    line_merged[{off, 5'b0} +: 32] = proc_wdata;
    write_hit  = (state_q == StIdle) & proc_write & hit;
    fill       = (state_q == StAllocate) & mem_ready;
  end

  // Stall is forced low while reset is held so an abandoned miss releases the
  // pipeline immediately.
  assign proc_stall = ~rst & ((state_q != StIdle) | (req & ~hit));
  assign proc_rdata = line_valid ? line_word : 32'h0;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Control FSM with registered memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req && !hit) begin
            if (line_valid && line_dirty) begin
              state_q     <= StWriteback;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {line_tag, idx};
              mem_wdata_q <= line_data;
            end else begin
              state_q    <= StAllocate;
              mem_read_q <= 1'b1;
              mem_addr_q <= {ptag, idx};
            end
          end else if (write_hit) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        StWriteback: begin
          if (mem_ready) begin
            // Hand straight over to the fill; the two requests never overlap.
            state_q      <= StAllocate;
            dirty_q[idx] <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b1;
            mem_addr_q   <= {ptag, idx};
          end
        end
        StAllocate: begin
          if (mem_ready) begin
            state_q      <= StIdle;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            mem_read_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Tag/data arrays. Writes are qualified by FSM state, which is held in IDLE
  // during reset, and a write hit needs a valid line.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= ptag;
    end else if (write_hit) begin
      data_q[idx] <= line_merged;
    end
  end

  // Memory requests are exclusive and held stable until acknowledged.
  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(mem_read_q && mem_write_q));

  a_write_held: assert property (@(posedge clk) disable iff (rst)
    (mem_write_q && !mem_ready) |=>
      (mem_write_q && $stable(mem_addr_q) && $stable(mem_wdata_q)));

  a_read_held: assert property (@(posedge clk) disable iff (rst)
    (mem_read_q && !mem_ready) |=> (mem_read_q && $stable(mem_addr_q)));

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Self-checking bench for dcache_dm_wb. The reference is a flat word memory
// plus a per-index residency table; the cache must behave as a transparent
// memory with the stated miss latencies.
module tb_dcache_dm_wb;

  logic         clk;
  logic         rst;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  dcache_dm_wb dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  ref_mem [int];   // processor-visible word memory
  logic [127:0] backing [int];   // what the memory device actually holds
  bit           rvalid  [8];
  bit           rdirty  [8];
  logic [24:0]  rtag    [8];

  function automatic logic [31:0] init_word(input logic [27:0] b, input logic [1:0] w);
    logic [31:0] k;
    k = 32'h11111111;
    if (b == 28'h4) return k * (32'(w) + 32'd1);
    return {4'hA, b[23:0], 2'b00, w};
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a[29:2], a[1:0]);
  endfunction

  function automatic logic [127:0] ref_block(input logic [27:0] b);
    return {ref_word({b, 2'd3}), ref_word({b, 2'd2}), ref_word({b, 2'd1}), ref_word({b, 2'd0})};
  endfunction

  function automatic logic [127:0] backing_block(input logic [27:0] b);
    if (backing.exists(int'(b))) return backing[int'(b)];
    return {init_word(b, 2'd3), init_word(b, 2'd2), init_word(b, 2'd1), init_word(b, 2'd0)};
  endfunction

  // ---------------- memory responder ----------------
  int lat   = 3;
  int cnt   = 0;
  bit noise = 0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (mem_read || mem_write) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          mem_ready = 1'b1;
          if (mem_write) backing[int'(mem_addr)] = mem_wdata;
          else mem_rdata = backing_block(mem_addr);
        end
      end else begin
        cnt = 0;
        if (noise) begin
          mem_ready = 1'($urandom_range(0, 1));
          mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  // ---------------- current transaction ----------------
  bit          chk_en = 0;
  bit          busy   = 0;
  bit          done   = 0;
  bit          cur_rd, cur_wr;
  logic [29:0] cur_addr;
  logic [31:0] cur_wdata;
  bit          exp_miss, exp_dirty;
  logic [27:0] exp_victim;
  int          exp_stall;
  int          stall_cnt;
  bit          saw_rd, saw_wr;
  logic [27:0] rd_addr, wb_addr;
  logic [127:0] wb_data;
  logic [31:0] last_rdata;
  int          last_stall;

  // Compare process: invariants every cycle, transaction result at completion.
  initial forever begin
    @(negedge clk);
    if (chk_en && !rst) begin
      check("rw_overlap", {mem_read, mem_write} == 2'b11, 0);
      if (mem_write) begin
        saw_wr  = 1;
        wb_addr = mem_addr;
        wb_data = mem_wdata;
        check("wb_addr", mem_addr, exp_victim);
        check("wb_data", mem_wdata, ref_block(exp_victim));
      end
      if (mem_read) begin
        saw_rd  = 1;
        rd_addr = mem_addr;
        check("fill_addr", mem_addr, cur_addr[29:2]);
      end
      if (!busy) begin
        check("idle_stall", proc_stall, 0);
        check("idle_mem", {mem_read, mem_write}, 2'b00);
      end else if (!done) begin
        if (proc_stall) begin
          stall_cnt++;
        end else begin
          int i;
          i = int'(cur_addr[4:2]);
          check("stall_cycles", stall_cnt, exp_stall);
          check("saw_write", saw_wr, exp_dirty);
          check("saw_read", saw_rd, exp_miss);
          if (cur_rd) check("rdata", proc_rdata, ref_word(cur_addr));
          if (cur_wr) ref_mem[int'(cur_addr)] = cur_wdata;
          if (exp_miss) begin
            rvalid[i] = 1;
            rtag[i]   = cur_addr[29:5];
            rdirty[i] = 0;
          end
          if (cur_wr) rdirty[i] = 1;
          last_rdata = proc_rdata;
          last_stall = stall_cnt;
          done = 1;
        end
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [29:0] a, input logic [31:0] wd);
    int i;
    @(posedge clk);
    #1;
    i          = int'(a[4:2]);
    exp_miss   = !(rvalid[i] && rtag[i] == a[29:5]);
    exp_dirty  = exp_miss && rvalid[i] && rdirty[i];
    exp_victim = {rtag[i], a[4:2]};
    exp_stall  = !exp_miss ? 0 : (exp_dirty ? 2 * lat + 1 : lat + 1);
    cur_rd = rd; cur_wr = wr; cur_addr = a; cur_wdata = wd;
    saw_rd = 0; saw_wr = 0; stall_cnt = 0; done = 0;
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
    busy = 1;
    for (int k = 0; k < 300 && !done; k++) @(posedge clk);
    check("complete", done, 1);
    #1;
    proc_read = 0;
    proc_write = 0;
    busy = 0;
  endtask

  initial begin
    rst = 1'b1;
    proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
    for (int i = 0; i < 8; i++) begin rvalid[i] = 0; rdirty[i] = 0; rtag[i] = '0; end
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", proc_stall, 0);
    check("rst_rdata", proc_rdata, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    #2 rst = 1'b0;
    chk_en = 1;

    // Clean miss, memory latency 3.
    lat = 3;
    access(1, 0, 30'h10, 0);
    check("t1_stall", last_stall, 4);
    check("t1_rdata", last_rdata, 32'h11111111);
    check("t1_fill_addr", rd_addr, 28'h4);

    // Write hit, then read back with no memory traffic.
    access(0, 1, 30'h11, 32'hDEADBEEF);
    check("t2_stall", last_stall, 0);
    access(1, 0, 30'h11, 0);
    check("t3_rdata", last_rdata, 32'hDEADBEEF);
    check("t3_traffic", {saw_rd, saw_wr}, 2'b00);

    // Conflict on index 4 with dirty victim.
    access(1, 0, 30'h211, 0);
    check("t4_stall", last_stall, 7);
    check("t4_wb_addr", wb_addr, 28'h4);
    check("t4_wb_word1", wb_data[63:32], 32'hDEADBEEF);
    check("t4_fill_addr", rd_addr, 28'h84);
    check("t4_rdata", last_rdata, 32'hA0000841);

    // Evicted line comes back clean with the written word.
    access(1, 0, 30'h11, 0);
    check("t5_stall", last_stall, 4);
    check("t5_no_wb", saw_wr, 0);
    check("t5_rdata", last_rdata, 32'hDEADBEEF);

    // Latency 1: write miss, read+write, dirty conflict.
    lat = 1;
    access(0, 1, 30'h2A, 32'hCAFEF00D);
    check("t6_stall", last_stall, 2);
    access(1, 1, 30'h29, 32'h12345678);
    check("t7_rdata_old", last_rdata, 32'hA00000A1);
    access(1, 0, 30'h3A9, 0);
    check("t8_stall", last_stall, 3);

    // Latency 2: refill of the written-back block, and a dirty line left behind.
    lat = 2;
    access(1, 0, 30'h2A, 0);
    check("t9_rdata", last_rdata, 32'hCAFEF00D);
    access(1, 0, 30'h29, 0);
    access(0, 1, 30'h7F, 32'h0BADC0DE);
    access(1, 0, 30'h7F, 0);

    // Reset in the middle of ALLOCATE.
    lat = 3;
    @(posedge clk);
    #1;
    chk_en = 0;
    proc_read = 1;
    proc_addr = 30'h50;
    repeat (3) @(negedge clk);
    check("mid_mem_read", mem_read, 1);
    check("mid_stall", proc_stall, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_mem_read", mem_read, 0);
    check("abort_mem_write", mem_write, 0);
    check("abort_stall", proc_stall, 0);
    @(posedge clk);
    #1;
    proc_read = 0;
    // Dirty data never written back is lost with the valid bits.
    for (int i = 0; i < 8; i++) begin
      if (rvalid[i] && rdirty[i]) begin
        for (int w = 0; w < 4; w++) begin
          logic [27:0]  b;
          logic [127:0] blk;
          b   = {rtag[i], 3'(i)};
          blk = backing_block(b);
          ref_mem[int'({b, 2'(w)})] = blk[32*w +: 32];
        end
      end
      rvalid[i] = 0;
      rdirty[i] = 0;
    end
    @(negedge clk);
    #2 rst = 1'b0;
    chk_en = 1;

    access(1, 0, 30'h10, 0);
    check("t10_stall", last_stall, 4);
    check("t10_rdata", last_rdata, 32'h11111111);
    access(1, 0, 30'h7F, 0);
    check("t11_lost_write", last_rdata, 32'hA00001F3);

    // Idle with stray mem_ready pulses: nothing may move.
    noise = 1;
    repeat (10) @(posedge clk);
    noise = 0;
    @(posedge clk);
    access(1, 0, 30'h10, 0);
    check("t12_stall", last_stall, 0);
    check("t12_rdata", last_rdata, 32'h11111111);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
